// File: rtl/pulse_pkg.sv
// Shared types and constants for the pulse train generator.
package pulse_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int WIDTH_DEF   = 16;
    localparam int BURST_W_DEF = 8;
    localparam int CLAMP_MIN   = 2;

endpackage

// File: rtl/pulse_timer.sv
// Loadable down-counter; expire marks the last cycle of a phase (value == 1).
module pulse_timer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] value,
    output logic             expire
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            value <= '0;
        else if (load)
            value <= load_val;
        else if (value != '0)
            value <= value - WIDTH'(1);
    end

    assign expire = (value == WIDTH'(1));

endmodule

// File: rtl/pulse_train_gen.sv
// Burst pulse-train generator: H cycles high, P-H cycles low, N pulses or until stop.
module pulse_train_gen
    import pulse_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int BURST_W = BURST_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic [WIDTH-1:0]   period,
    input  logic [WIDTH-1:0]   high_len,
    input  logic [BURST_W-1:0] burst_cnt,
    output logic               so,
    output logic               edge_tick,
    output logic               busy,
    output logic               done_tick
);

    state_t               state, state_nx;
    logic [WIDTH-1:0]     p_lat, h_lat, p_clamp, h_clamp;
    logic [WIDTH-1:0]     load_val, tmr_val;
    logic [BURST_W-1:0]   n_lat, pulse_num;
    logic                 stop_pending, load, expire, last_pulse;
    logic                 unused_tmr;

    pulse_timer #(.WIDTH(WIDTH)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .load_val (load_val),
        .value    (tmr_val),
        .expire   (expire)
    );

    // Phase sequencing only needs the expire strobe.
    assign unused_tmr = ^tmr_val;

    always_comb begin
        p_clamp = (period < WIDTH'(CLAMP_MIN)) ? WIDTH'(CLAMP_MIN) : period;
        if (high_len == '0)
            h_clamp = WIDTH'(1);
        else if (high_len >= p_clamp)
            h_clamp = p_clamp - WIDTH'(1);
        else
            h_clamp = high_len;
    end

    assign last_pulse = (n_lat != '0) && (pulse_num == n_lat);

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        load_val = h_lat;
        case (state)
            IDLE: if (start) begin
                state_nx = HIGH;
                load     = 1'b1;
                load_val = h_clamp;
            end
            HIGH: if (expire) begin
                state_nx = LOW;
                load     = 1'b1;
                load_val = p_lat - h_lat;
            end
            // A stop arriving on the final low cycle still ends this period.
            LOW: if (expire) begin
                if (last_pulse || stop_pending || stop) begin
                    state_nx = DONE;
                end else begin
                    state_nx = HIGH;
                    load     = 1'b1;
                    load_val = h_lat;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            p_lat        <= '0;
            h_lat        <= '0;
            n_lat        <= '0;
            pulse_num    <= '0;
            stop_pending <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && start) begin
                p_lat        <= p_clamp;
                h_lat        <= h_clamp;
                n_lat        <= burst_cnt;
                pulse_num    <= BURST_W'(1);
                stop_pending <= 1'b0;
            end else begin
                if ((state == HIGH || state == LOW) && stop)
                    stop_pending <= 1'b1;
                else if (state == DONE)
                    stop_pending <= 1'b0;
                if (state == LOW && state_nx == HIGH && n_lat != '0)
                    pulse_num <= pulse_num + BURST_W'(1);
            end
        end
    end

    // Outputs are registered from the next state so they align with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            so        <= 1'b0;
            edge_tick <= 1'b0;
            busy      <= 1'b0;
            done_tick <= 1'b0;
        end else begin
            so        <= (state_nx == HIGH);
            edge_tick <= (state_nx == HIGH) && (state != HIGH);
            busy      <= (state_nx == HIGH) || (state_nx == LOW);
            done_tick <= (state_nx == DONE);
        end
    end

endmodule

// File: tb/tb_pulse_train_gen.sv
// Self-checking bench: directed burst scenarios plus random traffic against an arithmetic model.
module tb_pulse_train_gen;

    localparam int W   = 8;
    localparam int B   = 4;
    localparam int BIG = 32'h7fff_ffff;

    logic         clk = 1'b0;
    logic         reset, start, stop;
    logic [W-1:0] period, high_len;
    logic [B-1:0] burst_cnt;
    logic         so, edge_tick, busy, done_tick;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: mode 0 idle, 1 busy at burst cycle k (1-based), 2 done cycle.
    int mode = 0;
    int k, mp, mh, end_k;

    always #5 clk = ~clk;

    pulse_train_gen #(.WIDTH(W), .BURST_W(B)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .period    (period),
        .high_len  (high_len),
        .burst_cnt (burst_cnt),
        .so        (so),
        .edge_tick (edge_tick),
        .busy      (busy),
        .done_tick (done_tick)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        int c;
        if (reset) begin
            mode = 0;
        end else if (mode == 1) begin
            if (stop) begin
                c = ((k + mp - 1) / mp) * mp;
                if (c < end_k) end_k = c;
            end
            if (k == end_k) mode = 2;
            else            k++;
        end else if (mode == 2) begin
            mode = 0;
        end else if (start) begin
            mp    = (int'(period) < 2) ? 2 : int'(period);
            mh    = (high_len == 0) ? 1 : ((int'(high_len) >= mp) ? mp - 1 : int'(high_len));
            end_k = (burst_cnt != 0) ? int'(burst_cnt) * mp : BIG;
            k     = 1;
            mode  = 1;
        end
    endtask

    task automatic check_outputs();
        chk("so",        so,        (mode == 1 && ((k - 1) % mp) < mh) ? 1 : 0);
        chk("edge_tick", edge_tick, (mode == 1 && ((k - 1) % mp) == 0) ? 1 : 0);
        chk("busy",      busy,      (mode == 1) ? 1 : 0);
        chk("done_tick", done_tick, (mode == 2) ? 1 : 0);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    // Launch a burst and run it out; done_at is the cycle offset from T of done_tick.
    task automatic burst(input int p, input int h, input int n, input int stop_at,
                         input int mid_at, input bit stop_with_start, input int max_cyc,
                         output int done_at);
        done_at   = -1;
        period    = W'(p);
        high_len  = W'(h);
        burst_cnt = B'(n);
        start     = 1'b1;
        stop      = stop_with_start;
        step();
        start = 1'b0;
        stop  = 1'b0;
        for (int i = 1; i <= max_cyc; i++) begin
            stop  = (i == stop_at);
            start = (i == mid_at);
            if (i == mid_at) begin
                period   = W'(3);
                high_len = W'(1);
            end
            step();
            if (done_tick && done_at < 0) done_at = i + 1;
            if (mode == 0 && done_at >= 0) break;
        end
        start = 1'b0;
        stop  = 1'b0;
    endtask

    initial begin
        int d;
        reset = 1'b1; start = 1'b0; stop = 1'b0;
        period = '0; high_len = '0; burst_cnt = '0;
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        reset = 1'b0;

        burst(10, 3, 4, -1, -1, 1'b0, 60, d);   chk("done_p10_n4", d, 41);
        burst(1, 0, 2, -1, -1, 1'b0, 20, d);    chk("done_clamp_p", d, 5);
        burst(8, 12, 1, -1, -1, 1'b0, 20, d);   chk("done_clamp_h", d, 9);
        burst(5, 2, 0, 7, -1, 1'b0, 40, d);     chk("done_stop", d, 11);
        burst(10, 3, 2, -1, 3, 1'b0, 40, d);    chk("done_mid_start", d, 21);
        burst(4, 1, 1, -1, -1, 1'b1, 20, d);    chk("done_start_stop", d, 5);
        burst(2, 1, 15, -1, -1, 1'b0, 60, d);   chk("done_n_max", d, 31);
        burst(255, 254, 2, -1, -1, 1'b0, 600, d); chk("done_p_max", d, 511);
        burst(6, 2, 0, 12, -1, 1'b0, 40, d);    chk("done_stop_last_low", d, 13);

        // Stop in idle must not pre-arm the next burst.
        stop = 1'b1; step(); step(); stop = 1'b0;
        burst(3, 1, 2, -1, -1, 1'b0, 20, d);    chk("done_idle_stop", d, 7);

        // Asynchronous reset mid-burst, then immediate restart.
        period = W'(10); high_len = W'(3); burst_cnt = '0; start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        #2 reset = 1'b1;
        #1;
        mode = 0;
        check_outputs();
        step();
        reset = 1'b0;
        step();
        period = W'(4); high_len = W'(2); burst_cnt = B'(1); start = 1'b1;
        step();
        chk("rise_after_reset", so, 1);
        start = 1'b0;
        for (int i = 0; i < 10; i++) step();
        chk("no_stale_done", done_tick, 0);

        for (int i = 0; i < 2500; i++) begin
            start     = ($urandom % 6) == 0;
            stop      = ($urandom % 30) == 0;
            period    = W'($urandom_range(0, 12));
            high_len  = W'($urandom_range(0, 14));
            burst_cnt = B'($urandom_range(0, 4));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
